// File: rtl/measure_duration.sv
// Measures the clock-cycle distance between a rising start event and a stop event,
// with optional timeout, saturating duration counter and an armed/done/ack handshake.
module measure_duration #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter bit          STOP_EDGE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [CNT_WIDTH-1:0] timeout_cycles,
  input  logic                 abort,
  input  logic                 start_evt,
  input  logic                 stop_evt,
  input  logic                 ack,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] duration,
  output logic                 timeout_flag,
  output logic                 ovf_flag
);

  localparam int unsigned CW1 = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ARMED    = 2'd1,
    S_COUNTING = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 start_h_q, start_h_d;
  logic                 stop_h_q, stop_h_d;
  logic [CNT_WIDTH-1:0] timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] elapsed_q, elapsed_d;
  logic [CNT_WIDTH-1:0] duration_q, duration_d;
  logic                 timeout_flag_q, timeout_flag_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 start_edge;
  logic                 stop_edge;
  logic                 timeout_hit;
  logic                 dur_sat;
  logic [CNT_WIDTH-1:0] dur_inc;
  logic [CNT_WIDTH-1:0] elapsed_inc;

  // Edge detection against last cycle's sampled level; counters saturate at all-ones.
  always_comb begin
    start_edge  = start_evt & ~start_h_q;
    stop_edge   = STOP_EDGE ? (stop_evt & ~stop_h_q) : (~stop_evt & stop_h_q);
    // Extra bit keeps elapsed+1 from wrapping back onto a small timeout value.
    timeout_hit = (timeout_q != '0) &&
                  ((CW1'(elapsed_q) + CW1'(1)) == CW1'(timeout_q));
    dur_sat     = (duration_q == CNT_MAX);
    dur_inc     = dur_sat ? duration_q : duration_q + CNT_WIDTH'(1);
    elapsed_inc = (elapsed_q == CNT_MAX) ? elapsed_q : elapsed_q + CNT_WIDTH'(1);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d        = state_q;
    start_h_d      = start_evt;
    stop_h_d       = stop_evt;
    timeout_d      = timeout_q;
    elapsed_d      = elapsed_q;
    duration_d     = duration_q;
    timeout_flag_d = timeout_flag_q;
    ovf_d          = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d        = S_ARMED;
          timeout_d      = timeout_cycles;
          elapsed_d      = '0;
          duration_d     = '0;
          timeout_flag_d = 1'b0;
          ovf_d          = 1'b0;
        end
      end
      S_ARMED: begin
        elapsed_d = elapsed_inc;
        if (timeout_hit) begin
          state_d        = S_DONE;
          timeout_flag_d = 1'b1;
        end else if (start_edge) begin
          state_d    = S_COUNTING;
          duration_d = '0;
        end
      end
      S_COUNTING: begin
        elapsed_d = elapsed_inc;
        if (stop_edge) begin
          // A stop coinciding with the timeout still counts as a clean stop.
          state_d    = S_DONE;
          duration_d = dur_inc;
          if (dur_sat) ovf_d = 1'b1;
        end else if (timeout_hit) begin
          state_d        = S_DONE;
          timeout_flag_d = 1'b1;
        end else begin
          duration_d = dur_inc;
          if (dur_sat) ovf_d = 1'b1;
        end
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d        = S_IDLE;
      duration_d     = '0;
      timeout_flag_d = 1'b0;
      ovf_d          = 1'b0;
    end
  end

  always_comb begin
    busy_d = (state_d == S_ARMED) || (state_d == S_COUNTING);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      start_h_q      <= 1'b0;
      stop_h_q       <= 1'b0;
      timeout_q      <= '0;
      elapsed_q      <= '0;
      duration_q     <= '0;
      timeout_flag_q <= 1'b0;
      ovf_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_h_q      <= start_h_d;
      stop_h_q       <= stop_h_d;
      timeout_q      <= timeout_d;
      elapsed_q      <= elapsed_d;
      duration_q     <= duration_d;
      timeout_flag_q <= timeout_flag_d;
      ovf_q          <= ovf_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign duration     = duration_q;
  assign timeout_flag = timeout_flag_q;
  assign ovf_flag     = ovf_q;

endmodule

// File: tb/tb_measure_duration.sv
// Directed bench for measure_duration: default, 4-bit saturating and falling-stop instances.
module tb_measure_duration;

  logic        clk;
  logic        rst;
  logic        arm;
  logic [31:0] timeout_cycles;
  logic        abort;
  logic        start_evt;
  logic        stop_evt;
  logic        ack;

  logic        busy, done, timeout_flag, ovf_flag;
  logic [31:0] duration;
  logic        s_busy, s_done, s_timeout_flag, s_ovf_flag;
  logic [3:0]  s_duration;
  logic        f_busy, f_done, f_timeout_flag, f_ovf_flag;
  logic [31:0] f_duration;

  int n_cmp;
  int n_err;

  measure_duration #(.CNT_WIDTH(32), .STOP_EDGE(1'b1)) dut (
    .clk(clk), .rst(rst), .arm(arm), .timeout_cycles(timeout_cycles), .abort(abort),
    .start_evt(start_evt), .stop_evt(stop_evt), .ack(ack),
    .busy(busy), .done(done), .duration(duration),
    .timeout_flag(timeout_flag), .ovf_flag(ovf_flag)
  );

  measure_duration #(.CNT_WIDTH(4), .STOP_EDGE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .arm(arm), .timeout_cycles(timeout_cycles[3:0]), .abort(abort),
    .start_evt(start_evt), .stop_evt(stop_evt), .ack(ack),
    .busy(s_busy), .done(s_done), .duration(s_duration),
    .timeout_flag(s_timeout_flag), .ovf_flag(s_ovf_flag)
  );

  measure_duration #(.CNT_WIDTH(32), .STOP_EDGE(1'b0)) dut_fall (
    .clk(clk), .rst(rst), .arm(arm), .timeout_cycles(timeout_cycles), .abort(abort),
    .start_evt(start_evt), .stop_evt(stop_evt), .ack(ack),
    .busy(f_busy), .done(f_done), .duration(f_duration),
    .timeout_flag(f_timeout_flag), .ovf_flag(f_ovf_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle 1 time unit so inputs change and outputs are read away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; arm = 1'b0; timeout_cycles = '0; abort = 1'b0;
    start_evt = 1'b0; stop_evt = 1'b0; ack = 1'b0;
    ticks(2);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_duration", 64'(duration), 64'd0);
    chk("rst_tflag", 64'(timeout_flag), 64'd0);
    chk("rst_ovf", 64'(ovf_flag), 64'd0);

    // ack in IDLE is ignored
    ack = 1'b1; tick(); ack = 1'b0;
    chk("idle_ack_busy", 64'(busy), 64'd0);
    chk("idle_ack_done", 64'(done), 64'd0);

    // Basic: arm at edge 0, start at edge 5, stop at edge 12 -> duration 7
    timeout_cycles = 32'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("basic_armed_busy", 64'(busy), 64'd1);
    ticks(4);
    start_evt = 1'b1; tick();
    chk("basic_counting_busy", 64'(busy), 64'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("counting_ack_busy", 64'(busy), 64'd1);
    chk("counting_ack_done", 64'(done), 64'd0);
    ticks(5);
    stop_evt = 1'b1; tick();
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_busy", 64'(busy), 64'd0);
    chk("basic_duration", 64'(duration), 64'd7);
    chk("basic_tflag", 64'(timeout_flag), 64'd0);
    chk("basic_ovf", 64'(ovf_flag), 64'd0);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("done_arm_done", 64'(done), 64'd1);
    chk("done_arm_duration", 64'(duration), 64'd7);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_done", 64'(done), 64'd0);
    chk("ack_busy", 64'(busy), 64'd0);
    chk("ack_duration_kept", 64'(duration), 64'd7);
    start_evt = 1'b0; stop_evt = 1'b0; tick();

    // Timeout 20: start at edge 3, done exactly at edge 20 with duration 16
    timeout_cycles = 32'd20;
    arm = 1'b1; tick(); arm = 1'b0;
    ticks(2);
    start_evt = 1'b1; tick();
    ticks(16);
    chk("to_edge19_busy", 64'(busy), 64'd1);
    chk("to_edge19_done", 64'(done), 64'd0);
    tick();
    chk("to_done", 64'(done), 64'd1);
    chk("to_tflag", 64'(timeout_flag), 64'd1);
    chk("to_duration", 64'(duration), 64'd16);
    ack = 1'b1; tick(); ack = 1'b0;
    start_evt = 1'b0; tick();

    // Start and stop together -> COUNTING; stop edge 4 cycles later -> duration 4
    timeout_cycles = 32'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    ticks(2);
    start_evt = 1'b1; stop_evt = 1'b1; tick();
    chk("simul_busy", 64'(busy), 64'd1);
    chk("simul_done", 64'(done), 64'd0);
    stop_evt = 1'b0; tick();
    ticks(2);
    stop_evt = 1'b1; tick();
    chk("simul_done2", 64'(done), 64'd1);
    chk("simul_duration", 64'(duration), 64'd4);
    ack = 1'b1; tick(); ack = 1'b0;
    start_evt = 1'b0; stop_evt = 1'b0; tick();

    // Stop in the timeout cycle: timeout 10, start edge 2, stop edge 10
    timeout_cycles = 32'd10;
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    start_evt = 1'b1; tick();
    ticks(7);
    stop_evt = 1'b1; tick();
    chk("stop_vs_to_done", 64'(done), 64'd1);
    chk("stop_vs_to_tflag", 64'(timeout_flag), 64'd0);
    chk("stop_vs_to_duration", 64'(duration), 64'd8);
    ack = 1'b1; tick(); ack = 1'b0;
    start_evt = 1'b0; stop_evt = 1'b0; tick();

    // Saturation on the 4-bit instance: stop 20 cycles after start
    abort = 1'b1; tick(); abort = 1'b0;
    timeout_cycles = 32'd0;
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    start_evt = 1'b1; tick();
    ticks(19);
    stop_evt = 1'b1; tick();
    chk("sat_done", 64'(s_done), 64'd1);
    chk("sat_duration", 64'(s_duration), 64'd15);
    chk("sat_ovf", 64'(s_ovf_flag), 64'd1);
    chk("sat_tflag", 64'(s_timeout_flag), 64'd0);
    chk("wide_duration", 64'(duration), 64'd20);
    chk("wide_ovf", 64'(ovf_flag), 64'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    start_evt = 1'b0; stop_evt = 1'b0; tick();

    // Falling-stop instance: stop_evt falls 6 cycles after start
    stop_evt = 1'b1; abort = 1'b1; tick(); abort = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    start_evt = 1'b1; tick();
    ticks(5);
    chk("fall_pre_done", 64'(f_done), 64'd0);
    stop_evt = 1'b0; tick();
    chk("fall_done", 64'(f_done), 64'd1);
    chk("fall_duration", 64'(f_duration), 64'd6);
    abort = 1'b1; tick(); abort = 1'b0;
    start_evt = 1'b0; tick();

    // Abort during COUNTING clears duration and returns to IDLE
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    start_evt = 1'b1; tick();
    ticks(3);
    chk("abort_pre_busy", 64'(busy), 64'd1);
    chk("abort_pre_duration", 64'(duration), 64'd3);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_duration", 64'(duration), 64'd0);
    chk("abort_tflag", 64'(timeout_flag), 64'd0);

    // arm together with abort stays in IDLE
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    chk("arm_abort_busy", 64'(busy), 64'd0);
    tick();
    chk("arm_abort_busy2", 64'(busy), 64'd0);

    // Reset while ARMED
    start_evt = 1'b0; tick();
    timeout_cycles = 32'd5;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rst_armed_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_armed_busy", 64'(busy), 64'd0);
    chk("rst_armed_done", 64'(done), 64'd0);
    chk("rst_armed_duration", 64'(duration), 64'd0);
    ticks(8);
    chk("rst_no_timeout_done", 64'(done), 64'd0);
    chk("rst_no_rearm_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/measure_duration.md
Name: measure_duration

Overview:
- Testbench-library timing block: the measuring end of the wait-duration mechanism. Instead of waiting a given duration, it measures the clock-cycle distance between a start event and a stop event.
- Used by scenario sequencers to check that DUT latencies fall within bounds.
- Armed by a command, counts cycles between the start and stop edges, then holds the result until acknowledged.
- Fully synchronous to one clock.

Parameters:
- CNT_WIDTH, 32, width of the duration, timeout and elapsed counters.
- STOP_EDGE, 1, edge polarity detected on stop_evt: 1 = rising, 0 = falling. start_evt is always rising.

Ports:
- clk  input  1  sole clock, all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- arm  input  1  single-cycle request to start a measurement; honoured only in IDLE.
- timeout_cycles  input  CNT_WIDTH  timeout limit, latched on an accepted arm; 0 = no timeout.
- abort  input  1  return to IDLE from any state.
- start_evt  input  1  start event signal (level).
- stop_evt  input  1  stop event signal (level).
- ack  input  1  result acknowledge; honoured only in DONE.
- busy  output  1  high in ARMED and COUNTING.
- done  output  1  high in DONE.
- duration  output  CNT_WIDTH  measured cycle count; valid while done.
- timeout_flag  output  1  measurement ended by timeout; valid while done.
- ovf_flag  output  1  duration saturated; valid while done.

Behaviour:
- Reset: state = IDLE; all outputs 0; internal counters, latched timeout and edge-history flops = 0.
- Edge detection:
  - start_h and stop_h register start_evt and stop_evt every non-reset cycle.
  - start_edge = start_evt & ~start_h.
  - stop_edge = stop_evt & ~stop_h when STOP_EDGE=1; ~stop_evt & stop_h when STOP_EDGE=0.
  - An event is therefore registered in the cycle where the new level is first sampled.
- FSM states: IDLE, ARMED, COUNTING, DONE.
- IDLE:
  - arm=1 -> ARMED next cycle.
  - On the arm edge: latch timeout_cycles; elapsed = 0; duration = 0; clear both flags.
  - ack is ignored.
- ARMED:
  - elapsed increments every cycle.
  - start_edge -> COUNTING; duration counter = 0.
  - A stop_edge in the same cycle as start_edge is ignored; stop must arrive strictly later.
- COUNTING:
  - duration += 1 each cycle; elapsed += 1.
  - stop_edge -> DONE with duration = T_stop - T_start, where T is the cycle of edge detection. Minimum duration is 1.
  - duration saturates at all-ones; ovf_flag set at saturation and held. Counting continues until stop or timeout.
- Timeout:
  - Applies in ARMED or COUNTING when latched timeout != 0 and elapsed + 1 == timeout. Next state is DONE with timeout_flag = 1; duration holds its current value (0 if start never occurred).
  - elapsed saturates and never wraps.
  - If stop_edge and timeout occur in the same cycle, stop wins: timeout_flag = 0.
- DONE:
  - done = 1; duration and flags stable.
  - ack=1 -> IDLE next cycle. Outputs keep their values until the next accepted arm.
  - arm is ignored while in DONE.
- Abort:
  - From any state -> IDLE next cycle; duration and flags cleared to 0.
  - abort has priority over arm, ack, events and timeout in the same cycle.
- Reset mid-operation: identical to power-on reset. The next measurement requires a new arm.
- busy = (state == ARMED || state == COUNTING); done = (state == DONE). Both are registered-state decodes with no combinational path from inputs.

Test Plan:
- Basic measurement: arm at cycle 0 with timeout=0; start_evt rises at cycle 5; stop_evt rises at cycle 12 -> done=1 at cycle 13, duration=7, timeout_flag=0, ovf_flag=0. Then ack -> done=0 and busy=0 next cycle.
- Timeout: arm with timeout_cycles=20; start at cycle 3; stop never arrives -> done with timeout_flag=1 exactly 20 cycles after arm was accepted, duration=16.
- Simultaneous events: start and stop rise in the same cycle -> state COUNTING, not DONE. A second stop edge 4 cycles later -> duration=4. Separately, stop edge in the same cycle as the timeout -> timeout_flag=0.
- Saturation: CNT_WIDTH=4, no timeout, stop at 20 cycles after start -> duration=15, ovf_flag=1. STOP_EDGE=0 variant: stop_evt falling 6 cycles after start -> duration=6.
- Abort and reset: abort during COUNTING -> IDLE next cycle, duration=0, flags=0. arm asserted together with abort -> stays IDLE. rst pulsed in ARMED -> IDLE and all outputs 0.
- Ignored commands: arm while DONE -> result unchanged; ack while IDLE or COUNTING -> no effect.
